result_sevenseg_driver: RTL and testbench



---
 rtl/result_sevenseg_driver.sv | 134 +++++++++++++
 tb/tb_result_sevenseg_driver.sv | 117 +++++++++++
 2 files changed

// File: rtl/result_sevenseg_driver.sv
// result_sevenseg_driver: renders a 32-bit result as 8 hex digits on a
// multiplexed, active-low 7-segment display. New results are captured at any
// time but only committed to the displayed (shadow) value at frame boundaries,
// so one scan frame never shows a mix of old and new digits.
// Optional build macro: SEVENSEG_LEADING_ZERO_BLANK_EN blanks the digits above
// the most-significant nonzero nibble (digit 0 always stays lit).
module result_sevenseg_driver #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result_in,
    input  logic        result_valid,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned      CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [31:0]      capture_q, capture_d;
    logic [31:0]      shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic             frame_end;
    logic [3:0]       nibble;
    logic             blank;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    logic [2:0]       msn;
`endif

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Next-state: scan divider, digit pointer, capture/commit, output decode.
    always_comb begin
        tick      = (div_cnt_q == CNT_LAST);
        frame_end = tick && (digit_idx_q == 3'd7);

        div_cnt_d   = tick ? '0 : div_cnt_q + CNT_W'(1);
        digit_idx_d = tick ? digit_idx_q + 3'd1 : digit_idx_q;

        capture_d = result_valid ? result_in : capture_q;
        pending_d = pending_q | result_valid;
        shadow_d  = shadow_q;
        if (frame_end) begin
            // A strobe landing exactly on the boundary goes straight to the
            // shadow so it is not delayed by a whole extra frame.
            if (result_valid) begin
                shadow_d  = result_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                shadow_d  = capture_q;
                pending_d = 1'b0;
            end
        end

        nibble = shadow_q[{digit_idx_q, 2'b00} +: 4];

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        msn = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (shadow_q[4*i +: 4] != 4'h0) msn = 3'(i);
        end
        blank = (digit_idx_q > msn);
`else
        blank = 1'b0;
`endif

        an_d         = blank ? 8'hFF : ~(8'h01 << digit_idx_q);
        seg_d        = blank ? 7'h7F : hex_to_seg(nibble);
        dp_d         = blank ? 1'b1  : (digit_idx_q != 3'd4);
        frame_done_d = frame_end;
    end

    // State and registered outputs with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= 3'd0;
            capture_q    <= 32'h0;
            shadow_q     <= 32'h0;
            pending_q    <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            capture_q    <= capture_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_result_sevenseg_driver.sv
// Directed bench for result_sevenseg_driver with SCAN_DIV=4 (32-cycle frames).
// Expected outputs come from a frame-level model: each frame shows the value
// of the last strobe seen before that frame began.
module tb_result_sevenseg_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result_in;
    logic        result_valid;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int e = 0;                  // index of the last non-reset edge
    logic [31:0] disp = 32'h0;  // value shown in the current frame
    logic [31:0] next_disp = 32'h0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    result_sevenseg_driver #(.SCAN_DIV(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_in    (result_in),
        .result_valid (result_valid),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int top_nibble(input logic [31:0] v);
        int m = 0;
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) m = i;
        return m;
    endfunction

    // One clock: drive at negedge, sample 1 time unit after posedge, compare.
    task automatic cycle(input logic r, input logic v, input logic [31:0] d);
        int  dig;
        logic blk;
        logic [3:0] nib;
        @(negedge clk);
        rst = r; result_valid = v; result_in = d;
        @(posedge clk);
        #1;
        if (r) begin
            check("rst_an", {24'h0, an}, 32'hFF);
            check("rst_seg", {25'h0, seg}, 32'h7F);
            check("rst_dp", {31'h0, dp}, 32'h1);
            check("rst_fd", {31'h0, frame_done}, 32'h0);
            e = 0; disp = 32'h0; next_disp = 32'h0;
        end else begin
            if (v) next_disp = d;
            if (e % 32 == 0) disp = next_disp;
            dig = (e / 4) % 8;
            nib = disp[4*dig +: 4];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
            blk = (dig > top_nibble(disp));
`else
            blk = 1'b0;
`endif
            check($sformatf("an e=%0d", e), {24'h0, an}, blk ? 32'hFF : {24'h0, ~(8'h01 << dig)});
            check($sformatf("seg e=%0d", e), {25'h0, seg}, blk ? 32'h7F : {25'h0, hex_tab[nib]});
            check($sformatf("dp e=%0d", e), {31'h0, dp}, (blk || dig != 4) ? 32'h1 : 32'h0);
            check($sformatf("fd e=%0d", e), {31'h0, frame_done}, (e % 32 == 31) ? 32'h1 : 32'h0);
            e++;
        end
    endtask

    initial begin
        rst = 1'b1; result_valid = 1'b0; result_in = 32'h0;
        // Reset held 3 cycles, with a strobe that must be ignored.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'hDEADBEEF);

        // Free run, mid-frame update, double strobe, boundary strobe, pending
        // strobe then reset mid-frame.
        for (int i = 0; i < 205; i++) begin
            case (i)
                73:      cycle(1'b0, 1'b1, 32'h1234ABCD);
                130:     cycle(1'b0, 1'b1, 32'h11111111);
                140:     cycle(1'b0, 1'b1, 32'h0000000F);
                191:     cycle(1'b0, 1'b1, 32'hFFFFFFFF);
                198:     cycle(1'b0, 1'b1, 32'h12345678);
                default: cycle(1'b0, 1'b0, 32'h0);
            endcase
            if (i == 191) check("pending_after_boundary", {31'h0, dut.pending_q}, 32'h0);
        end
        cycle(1'b1, 1'b0, 32'h0);

        // After reset the discarded capture must not appear; then A5 and 0.
        for (int i = 0; i < 128; i++) begin
            case (i)
                40:      cycle(1'b0, 1'b1, 32'h000000A5);
                70:      cycle(1'b0, 1'b1, 32'h00000000);
                default: cycle(1'b0, 1'b0, 32'h0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
